// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode: 256x24 program store issuing decoded fields through a one-deep output slot.
// Define IFD_HAZARD_STALL_EN to add an rd scoreboard that stalls RAW-dependent issues.
module instr_fetch_decode #(
  parameter logic [7:0] START_PC  = 8'h00,
  parameter logic [3:0] HALT_FUNC = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [23:0] prog_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW    = 8;
  localparam int unsigned FW    = 4;
  localparam int unsigned WW    = 24;
  localparam int unsigned DEPTH = 256;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   pc_q, pc_d;
  logic            out_valid_q, out_valid_d;
  logic [FW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, func_q, func_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            busy_q, done_q;

  logic [FW-1:0]   f_func, f_rd, f_rs1, f_rs2;
  logic [AW-1:0]   f_addr;
  logic            slot_free, is_halt, reserved, hazard, issue;

  assign {f_func, f_rd, f_rs1, f_rs2, f_addr} = mem_q[pc_q];
  assign slot_free = !out_valid_q || out_ready;
  assign is_halt   = (f_func == HALT_FUNC);
  assign reserved  = (f_func >= FW'(11)) && (f_func <= FW'(14));
  assign issue     = (state_q == ST_RUN) && slot_free && !is_halt && !reserved && !hazard;

  // Program store; writes are locked out while a program is running.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q != ST_RUN)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

`ifdef IFD_HAZARD_STALL_EN
  // Each issued rd is checked for the two cycles after issue, so a dependent
  // instruction lands three edges after its producer.
  localparam int unsigned SB_DEPTH = 2;

  logic [SB_DEPTH-1:0]         sb_vld_q;
  logic [SB_DEPTH-1:0][FW-1:0] sb_rd_q;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_vld_q[i] && ((sb_rd_q[i] == f_rs1) || (sb_rd_q[i] == f_rs2))) begin
        hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_vld_q <= '0;
      sb_rd_q  <= '0;
    end else begin
      sb_vld_q <= {sb_vld_q[SB_DEPTH-2:0], issue};
      sb_rd_q  <= {sb_rd_q[SB_DEPTH-2:0], f_rd};
    end
  end
`else
  assign hazard = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= START_PC;
      out_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      func_q      <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      func_q      <= func_d;
      addr_q      <= addr_d;
      busy_q      <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_HALT);
    end
  end

  // Next state: the slot only advances when free; halt leaves pc on the halt word.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    func_d      = func_q;
    addr_d      = addr_q;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        out_valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          pc_d    = START_PC;
        end
      end
      ST_RUN: begin
        if (slot_free) begin
          out_valid_d = issue;
          if (is_halt) begin
            state_d = ST_HALT;
          end else if (reserved || issue) begin
            pc_d = pc_q + AW'(1);
          end
          if (issue) begin
            func_d = f_func;
            rd_d   = f_rd;
            rs1_d  = f_rs1;
            rs2_d  = f_rs2;
            addr_d = f_addr;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign func      = func_q;
  assign addr      = addr_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode against an instruction-level program model.
`timescale 1ns/1ps
module tb_instr_fetch_decode;

`ifdef IFD_HAZARD_STALL_EN
  localparam int DEP_GAP = 3;
`else
  localparam int DEP_GAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, start, start_ff, prog_we, out_ready;
  logic [7:0]  prog_addr;
  logic [23:0] prog_data;

  logic        out_valid, busy, done;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr, pc;
  logic        ff_valid, ff_busy, ff_done;
  logic [3:0]  ff_rs1, ff_rs2, ff_rd, ff_func;
  logic [7:0]  ff_addr, ff_pc;
  logic [23:0] word_o, ff_word;

  assign word_o  = {func, rd, rs1, rs2, addr};
  assign ff_word = {ff_func, ff_rd, ff_rs1, ff_rs2, ff_addr};

  instr_fetch_decode dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .out_ready(out_ready), .out_valid(out_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr), .pc(pc),
    .busy(busy), .done(done)
  );

  instr_fetch_decode #(.START_PC(8'hFF)) dut_ff (
    .clk(clk), .rst(rst), .start(start_ff), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .out_ready(out_ready), .out_valid(ff_valid),
    .rs1(ff_rs1), .rs2(ff_rs2), .rd(ff_rd), .func(ff_func), .addr(ff_addr), .pc(ff_pc),
    .busy(ff_busy), .done(ff_done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [23:0] model_mem [256];
  logic [23:0] exp_q [$];
  logic [23:0] got_q [$];
  int hold_err;
  bit timed_out;

  localparam logic [23:0] HALT_W = 24'hF00000;

  function automatic logic [23:0] mkw(input int f, input int d, input int s1, input int s2, input int a);
    return {4'(f), 4'(d), 4'(s1), 4'(s2), 8'(a)};
  endfunction

  // Instruction-level walk: issue non-reserved words in order until the halt word.
  function automatic int model_run(input logic [7:0] spc);
    logic [7:0] p;
    logic [3:0] f;
    p = spc;
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      f = model_mem[p][23:20];
      if (f == 4'hF) return int'(p);
      if (f < 4'd11) exp_q.push_back(model_mem[p]);
      p = p + 8'd1;
    end
    return -1;
  endfunction

  task automatic prog(input logic [7:0] a, input logic [23:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    model_mem[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Records consumed words until done; counts any slot change while stalled.
  task automatic collect(input bit rand_ready, input int max_cycles);
    logic [23:0] prev_w;
    bit prev_hold;
    got_q.delete();
    hold_err = 0; timed_out = 1'b1; prev_hold = 1'b0; prev_w = '0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (prev_hold && (out_valid !== 1'b1 || word_o !== prev_w)) hold_err++;
      if (done === 1'b1) begin timed_out = 1'b0; break; end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) got_q.push_back(word_o);
      prev_hold = out_valid && !out_ready;
      prev_w = word_o;
    end
  endtask

  function automatic int queue_diffs();
    int n;
    n = (got_q.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_ff = 1'b0; prog_we = 1'b0; out_ready = 1'b0;
    prog_addr = '0; prog_data = '0;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (pc !== 8'h00) $display("FAIL reset_pc got %h want 00", pc); else pass_cnt++;
    total_cnt++; if (word_o !== 24'h0) $display("FAIL reset_fields got %h want 000000", word_o); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b want 00", busy, done); else pass_cnt++;
    total_cnt++; if (ff_pc !== 8'hFF) $display("FAIL reset_pc_ff got %h want ff", ff_pc); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 256; i++) prog(8'(i), HALT_W);
  endtask

  task automatic test_basic();
    prog(8'd0, mkw(0, 10, 5, 4, 125));
    prog(8'd1, HALT_W);
    out_ready = 1'b1;
    pulse_start();
    total_cnt++; if (busy !== 1'b1 || out_valid !== 1'b0 || pc !== 8'h00)
      $display("FAIL basic_accept got busy=%b valid=%b pc=%h want 1 0 00", busy, out_valid, pc); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || word_o !== mkw(0, 10, 5, 4, 125))
      $display("FAIL basic_issue got valid=%b word=%h want 1 %h", out_valid, word_o, mkw(0, 10, 5, 4, 125)); else pass_cnt++;
    total_cnt++; if (pc !== 8'h01) $display("FAIL basic_pc_after_issue got %h want 01", pc); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || pc !== 8'h01)
      $display("FAIL basic_halt got valid=%b done=%b busy=%b pc=%h want 0 1 0 01", out_valid, done, busy, pc); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad;
    for (int i = 0; i < 4; i++)
      prog(8'(i), mkw($urandom_range(0, 10), i + 1, $urandom_range(8, 15), $urandom_range(8, 15), $urandom_range(0, 255)));
    prog(8'd4, HALT_W);
    void'(model_run(8'h00));
    out_ready = 1'b0;
    pulse_start();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || word_o !== exp_q[0])
      $display("FAIL bp_first got valid=%b word=%h want 1 %h", out_valid, word_o, exp_q[0]); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || word_o !== exp_q[0] || pc !== 8'h01) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL bp_frozen got %0d changed cycles want 0", bad); else pass_cnt++;
    out_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (out_valid !== 1'b1 || word_o !== exp_q[k]) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL bp_stream got %0d bad beats want 0", bad); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0 || done !== 1'b1)
      $display("FAIL bp_end got valid=%b done=%b want 0 1", out_valid, done); else pass_cnt++;
  endtask

  task automatic test_random();
    int len, hp;
    for (int it = 0; it < 3; it++) begin
      len = $urandom_range(6, 16);
      for (int i = 0; i < len; i++)
        prog(8'(i), mkw($urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 255)));
      prog(8'(len), HALT_W);
      hp = model_run(8'h00);
      pulse_start();
      collect(1'b1, 400);
      total_cnt++; if (timed_out) $display("FAIL rand_timeout iter %0d got no done want done", it); else pass_cnt++;
      total_cnt++; if (queue_diffs() != 0)
        $display("FAIL rand_sequence iter %0d got %0d words want %0d (%0d diffs)", it, got_q.size(), exp_q.size(), queue_diffs()); else pass_cnt++;
      total_cnt++; if (hold_err != 0) $display("FAIL rand_hold iter %0d got %0d changes want 0", it, hold_err); else pass_cnt++;
      total_cnt++; if (pc !== 8'(hp)) $display("FAIL rand_halt_pc iter %0d got %h want %h", it, pc, 8'(hp)); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    int bad;
    for (int i = 0; i < 6; i++)
      prog(8'(i), mkw($urandom_range(0, 10), i + 1, $urandom_range(8, 15), $urandom_range(8, 15), $urandom_range(0, 255)));
    prog(8'd6, HALT_W);
    out_ready = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pc === 8'h02) begin found = 1'b1; break; end
    end
    total_cnt++; if (!found || out_valid !== 1'b1)
      $display("FAIL rstrun_reach_pc2 got found=%b valid=%b want 1 1", found, out_valid); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || pc !== 8'h00 || busy !== 1'b0)
      $display("FAIL rstrun_immediate got valid=%b pc=%h busy=%b want 0 00 0", out_valid, pc, busy); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 8'h00) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL rstrun_idle got %0d active cycles want 0", bad); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [23:0] w;
    w = mkw(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
    prog(8'h00, HALT_W);
    prog(8'hFF, w);
    out_ready = 1'b1;
    @(negedge clk); start_ff = 1'b1;
    @(negedge clk); start_ff = 1'b0;
    total_cnt++; if (ff_busy !== 1'b1 || ff_pc !== 8'hFF)
      $display("FAIL wrap_accept got busy=%b pc=%h want 1 ff", ff_busy, ff_pc); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ff_valid !== 1'b1 || ff_word !== w || ff_pc !== 8'h00)
      $display("FAIL wrap_issue got valid=%b word=%h pc=%h want 1 %h 00", ff_valid, ff_word, ff_pc, w); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ff_valid !== 1'b0 || ff_done !== 1'b1 || ff_pc !== 8'h00)
      $display("FAIL wrap_halt got valid=%b done=%b pc=%h want 0 1 00", ff_valid, ff_done, ff_pc); else pass_cnt++;
  endtask

  task automatic test_hazard();
    int t1, t2;
    logic [23:0] w1;
    w1 = mkw(1, 12, 10, 3, $urandom_range(0, 255));
    prog(8'd0, mkw(0, 10, 5, 4, $urandom_range(0, 255)));
    prog(8'd1, w1);
    prog(8'd2, HALT_W);
    out_ready = 1'b1;
    pulse_start();
    t1 = -1; t2 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) begin
          t2 = k;
          total_cnt++; if (word_o !== w1) $display("FAIL hazard_word got %h want %h", word_o, w1); else pass_cnt++;
        end
      end
    end
    total_cnt++; if (t1 != 1) $display("FAIL hazard_first got cycle %0d want 1", t1); else pass_cnt++;
    total_cnt++; if (t2 - t1 != DEP_GAP || t2 < 0)
      $display("FAIL hazard_gap got %0d want %0d", t2 - t1, DEP_GAP); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL hazard_done got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_write_in_run();
    logic [23:0] orig1, neww;
    for (int i = 0; i < 3; i++)
      prog(8'(i), mkw($urandom_range(0, 10), i + 1, $urandom_range(8, 15), $urandom_range(8, 15), $urandom_range(0, 255)));
    prog(8'd3, HALT_W);
    orig1 = model_mem[1];
    out_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 8'd1; prog_data = ~orig1;
    @(negedge clk);
    prog_we = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || word_o !== orig1)
      $display("FAIL runwrite_issue got valid=%b word=%h want 1 %h", out_valid, word_o, orig1); else pass_cnt++;
    collect(1'b0, 20);
    total_cnt++; if (timed_out) $display("FAIL runwrite_timeout got no done want done"); else pass_cnt++;
    neww = mkw($urandom_range(0, 10), 7, $urandom_range(8, 15), $urandom_range(8, 15), $urandom_range(0, 255));
    @(negedge clk);
    start = 1'b1; prog_we = 1'b1; prog_addr = 8'd2; prog_data = neww;
    model_mem[2] = neww;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    void'(model_run(8'h00));
    collect(1'b0, 30);
    total_cnt++; if (timed_out || queue_diffs() != 0)
      $display("FAIL startwrite_sequence got %0d words timeout=%b want %0d words", got_q.size(), timed_out, exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    test_wrap();
    test_hazard();
    test_write_in_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
